phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
Parametrised one-hot machine-cycle timing generator for the 8-bit CPU model. It drives the control-step signals that sequence each instruction. It adds four things a fixed rotating ring does not have:
- configurable phase count
- per-instruction variable cycle length, with early terminate
- halt-at-boundary with single-instruction step
- stall freeze and a retired-instruction counter

It sits between the clock source and the control decoder.

Parameters:
- PHASES, 8: number of one-hot phases, valid range 2..16.
- PW, $clog2(PHASES): phase-index width (derived; do not override).
- CW, 16: width of the instruction counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- len  in  PW+1  cycle length for the next instruction. Sampled only when the sequencer enters phase 0.
- restart  in  1  early terminate: the next phase is 0.
- stall  in  1  freeze all state for this cycle.
- halt_req  in  1  request halt at the next instruction boundary. Level-sensitive.
- resume  in  1  pulse: leave HALT and run continuously.
- step  in  1  pulse: from HALT, execute exactly one instruction, then return to HALT.
- signals  out  PHASES  one-hot phase. Phase 0 = bit PHASES-1; phases advance toward bit 0.
- phase  out  PW  binary index of the current phase.
- last_phase  out  1  high when the current phase is the final phase of this instruction.
- halted  out  1  high in HALT.
- instr_cnt  out  CW  count of completed instructions; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - signals = 1<<(PHASES-1), phase = 0.
  - State RUN, halted = 0, instr_cnt = 0.
  - len_q = PHASES (effective length register).
  - Normal operation resumes on the first rising clk edge after rst returns high.
- Effective length:
  - On every entry to phase 0 (including the reset release cycle), len_q <= len.
  - len = 0 or len > PHASES is clamped to PHASES.
  - len = 1 is legal: the sequencer sits in phase 0 and completes one instruction every cycle.
- last_phase:
  - Combinational: (phase == len_q-1) OR restart.
  - Evaluate it against the len_q in effect for the current instruction. When phase=0 and a new len is being sampled, use the clamped len input.
- Boundary: a rising edge in RUN or STEP with stall=0 and last_phase=1.
  - Next phase is 0.
  - instr_cnt increments by 1, wrapping modulo 2^CW.
- Otherwise, in RUN or STEP with stall=0: phase increments by 1. signals is always the one-hot decode of phase, registered (no glitching).
- State machine (RUN, HALT, STEP), evaluated only when stall=0:
  - RUN: at a boundary with halt_req=1, go to HALT (phase becomes 0). Otherwise stay in RUN.
  - HALT:
    - phase held at 0, halted = 1, instr_cnt held, restart ignored.
    - step=1: go to STEP; the next edge advances from phase 0 as normal.
    - resume=1: go to RUN.
    - step and resume together: resume wins.
    - len is still sampled every cycle while in HALT (phase 0).
  - STEP: at a boundary, go to HALT regardless of halt_req. step and resume are ignored until then.
  - halt_req is ignored outside RUN boundaries. Asserting it mid-instruction never truncates the instruction.
- Priority per edge: rst > stall > restart > normal advance/boundary.
  - stall=1 freezes phase, state, len_q and instr_cnt.
  - last_phase still reflects restart during a stall, but nothing commits.
- Restart at phase 0 counts as a boundary: instr_cnt increments and phase stays 0.
- Reset mid-instruction or mid-STEP returns immediately to the reset values listed above.
- Invariant: signals is exactly one-hot at all times.

Test Plan:
- Reset, then 20 clocks with len=0 and PHASES=8 -> signals 0x80,0x40,…,0x01,0x80…; instr_cnt = 2 after 16 edges; last_phase high when signals = 0x01.
- len=3 continuously -> phase sequence 0,1,2,0,1,2; signals 0x80,0x40,0x20 repeating; instr_cnt increments every 3 edges; len=9 behaves as 8.
- Run with len=8, pulse restart while phase=4 -> next phase 0; instr_cnt +1; new len sampled at that phase 0.
- Assert halt_req at phase 2 -> continues through phase 7, then phase 0 with halted=1 and stays. Pulse step -> exactly 8 advances, then halted again with instr_cnt +1. Pulse resume -> free run.
- Hold stall for 5 cycles at phase 3, including a restart pulse and a halt_req during the stall -> phase, instr_cnt and state unchanged; advance resumes to phase 4 when stall drops.
- Drop rst asynchronously mid-clock at phase 5 in STEP -> signals = 0x80, halted = 0, instr_cnt = 0 before the next clk edge; preload instr_cnt = 0xFFFF -> wraps to 0x0000 at the next boundary.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot machine-cycle timing generator for the 8-bit CPU.
// Produces the control-step phase for each instruction. The instruction length
// can vary per instruction and an instruction can be cut short with restart.
// The sequencer can halt at an instruction boundary and single-step, and stall
// freezes all state. It also counts retired instructions.
module phase_sequencer #(
  parameter int PHASES = 8,
  parameter int PW     = $clog2(PHASES),
  parameter int CW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PW:0]       len,
  input  logic              restart,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              step,
  output logic [PHASES-1:0] signals,
  output logic [PW-1:0]     phase,
  output logic              last_phase,
  output logic              halted,
  output logic [CW-1:0]     instr_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [PW:0]       LEN_MAX   = (PW+1)'(PHASES);
  localparam logic [PW:0]       LEN_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0]     PH_ONE    = PW'(1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [PHASES-1:0] SIG_RESET = {1'b1, {(PHASES-1){1'b0}}};

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW:0]       len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PHASES-1:0] signals_q, signals_d;
  logic              halted_q, halted_d;

  logic [PW:0]       len_clamped;
  logic [PW:0]       len_eff;
  logic [PW:0]       last_idx;
  logic              at_end;

  // Length in force for the current instruction. In phase 0 the new length is
  // being sampled this cycle, so the clamped input applies directly.
  always_comb begin
    len_clamped = len;
    if (len == '0 || len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
    len_eff    = (phase_q == '0) ? len_clamped : len_q;
    last_idx   = len_eff - LEN_ONE;
    at_end     = ({1'b0, phase_q} == last_idx);
    last_phase = at_end | restart;
  end

  // Next-state logic for the run/halt/step machine, phase, length and counter.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    if (!stall) begin
      if (phase_q == '0) begin
        len_d = len_clamped;
      end
      case (state_q)
        S_HALT: begin
          phase_d = '0;
          if (resume) begin
            state_d = S_RUN;
          end else if (step) begin
            state_d = S_STEP;
          end
        end
        default: begin
          if (last_phase) begin
            phase_d = '0;
            cnt_d   = cnt_q + CNT_ONE;
            if (state_q == S_STEP) begin
              state_d = S_HALT;
            end else if (halt_req) begin
              state_d = S_HALT;
            end
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
      endcase
    end
    halted_d = (state_d == S_HALT);
  end

  // One-hot decode of the next phase: phase 0 is the MSB and advances downward.
  always_comb begin
    signals_d = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      signals_d[i] = (phase_d == PW'(PHASES - 1 - i));
    end
  end

  // State and registered outputs; reset returns to phase 0 in RUN immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      phase_q   <= '0;
      len_q     <= LEN_MAX;
      cnt_q     <= '0;
      signals_q <= SIG_RESET;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      signals_q <= signals_d;
      halted_q  <= halted_d;
    end
  end

  assign signals   = signals_q;
  assign phase     = phase_q;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

endmodule
